// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector result collector: element-width codes,
// collector states, lane geometry and the chunk-size rule.
package vec_pkg;

  localparam int LANE_MAX_W = 64;
  localparam int IDX_W      = 10;
  localparam int MAX_LANES  = 4;

  typedef enum logic [2:0] {
    VSEW_E8  = 3'd0,
    VSEW_E16 = 3'd1,
    VSEW_E32 = 3'd2,
    VSEW_E64 = 3'd3
  } vsew_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } state_e;

  // A chunk is one element, but never wider than a physical lane.
  function automatic logic [2:0] chunk_log2(input logic [2:0] vsew,
                                            input logic [2:0] lane_width);
    logic [3:0] sew_log2;
    sew_log2 = {1'b0, vsew} + 4'd3;
    return (sew_log2 > {1'b0, lane_width}) ? lane_width : sew_log2[2:0];
  endfunction

endpackage

// File: rtl/vec_chunk_writer.sv
// Per-lane index check and write-mask generation: turns one lane result into a
// VLEN-wide masked write plus a one-hot chunk marker, or flags a bad index.
module vec_chunk_writer
  import vec_pkg::*;
#(
  parameter  int VLEN = 128,
  localparam int BM_W = VLEN / 8
) (
  input  logic                  valid_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [LANE_MAX_W-1:0] data_i,
  input  logic [2:0]            cl2_i,
  output logic                  wr_en_o,
  output logic                  idx_err_o,
  output logic [VLEN-1:0]       mask_o,
  output logic [VLEN-1:0]       wdata_o,
  output logic [BM_W-1:0]       chunk_oh_o
);

  logic [VLEN-1:0]  chunk_ones;
  logic [IDX_W-1:0] align_mask;
  logic             idx_ok;

  // NOTE: every output gets a default before the conditional writes so no latch is inferred.
  always_comb begin
    chunk_ones = (VLEN'(1) << (32'd1 << cl2_i)) - VLEN'(1);
    align_mask = (IDX_W'(1) << cl2_i) - IDX_W'(1);
    idx_ok     = (idx_i < IDX_W'(VLEN)) && ((idx_i & align_mask) == '0);
    wr_en_o    = valid_i & idx_ok;
    idx_err_o  = valid_i & ~idx_ok;
    mask_o     = '0;
    wdata_o    = '0;
    chunk_oh_o = '0;
    if (valid_i && idx_ok) begin
      mask_o     = chunk_ones << idx_i;
      wdata_o    = (VLEN'(data_i) & chunk_ones) << idx_i;
      chunk_oh_o = BM_W'(1) << (idx_i >> cl2_i);
    end
  end

endmodule

// File: rtl/vec_result_collector.sv
// Assembles per-lane vector ALU results into a VLEN-bit destination and hands the
// completed register to the register file with a valid/ready handshake.
module vec_result_collector
  import vec_pkg::*;
#(
  parameter int         VLEN       = 128,
  parameter logic [2:0] LANE_WIDTH = 3'd4,
  parameter logic [1:0] NB_LANES   = 2'd2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [2:0]                      vsew,
  input  logic [MAX_LANES*LANE_MAX_W-1:0] lane_data,
  input  logic [MAX_LANES*IDX_W-1:0]      lane_idx,
  input  logic [MAX_LANES-1:0]            lane_valid,
  input  logic                            alu_done,
  output logic [VLEN-1:0]                 vd,
  output logic                            vd_valid,
  input  logic                            vd_ready,
  output logic                            busy,
  output logic                            err
);

  localparam int BM_W   = VLEN / 8;
  localparam int NLANES = 1 << NB_LANES;

  state_e          state_q, state_d;
  vsew_e           vsew_q, vsew_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic [BM_W-1:0] bitmap_q, bitmap_d;
  logic            err_q, err_d;

  logic [2:0]           cl2;
  logic [BM_W-1:0]      full_mask;
  logic [MAX_LANES-1:0] lane_en, wr_en, idx_err;
  logic [VLEN-1:0]      wr_mask  [MAX_LANES];
  logic [VLEN-1:0]      wr_data  [MAX_LANES];
  logic [BM_W-1:0]      chunk_oh [MAX_LANES];

  assign cl2       = chunk_log2(vsew_q, LANE_WIDTH);
  assign full_mask = {BM_W{1'b1}} >> (BM_W - (BM_W >> (cl2 - 3'd3)));

  for (genvar n = 0; n < MAX_LANES; n++) begin : g_lane
    // Lanes beyond the physical lane count never contribute.
    assign lane_en[n] = (n < NLANES) ? lane_valid[n] : 1'b0;

    vec_chunk_writer #(.VLEN(VLEN)) u_writer (
      .valid_i    (lane_en[n]),
      .idx_i      (lane_idx[n*IDX_W +: IDX_W]),
      .data_i     (lane_data[n*LANE_MAX_W +: LANE_MAX_W]),
      .cl2_i      (cl2),
      .wr_en_o    (wr_en[n]),
      .idx_err_o  (idx_err[n]),
      .mask_o     (wr_mask[n]),
      .wdata_o    (wr_data[n]),
      .chunk_oh_o (chunk_oh[n])
    );
  end

  always_comb begin
    state_d  = state_q;
    vsew_d   = vsew_q;
    vd_d     = vd_q;
    bitmap_d = bitmap_q;
    err_d    = err_q;
    if (start) begin
      state_d  = ST_COLLECT;
      vsew_d   = vsew_e'(vsew);
      vd_d     = '0;
      bitmap_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          // Lane order matters: a later lane wins when two target the same chunk.
          for (int n = 0; n < MAX_LANES; n++) begin
            if (wr_en[n]) begin
              vd_d     = (vd_d & ~wr_mask[n]) | wr_data[n];
              bitmap_d = bitmap_d | chunk_oh[n];
            end else if (idx_err[n]) begin
              err_d = 1'b1;
            end
          end
          if ((bitmap_d & full_mask) == full_mask) state_d = ST_HOLD;
          else if (alu_done)                       err_d   = 1'b1;
        end
        ST_HOLD: begin
          if (|lane_en) err_d   = 1'b1;
          if (vd_ready) state_d = ST_IDLE;
        end
        default: begin
          if (|lane_en) err_d = 1'b1;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vsew_q   <= VSEW_E8;
      vd_q     <= '0;
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsew_q   <= vsew_d;
      vd_q     <= vd_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

  assign vd       = vd_q;
  assign vd_valid = (state_q == ST_HOLD);
  assign busy     = (state_q == ST_COLLECT);
  assign err      = err_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Directed self-checking bench for vec_result_collector: assembly at two chunk
// widths, back-pressure, index/protocol errors, restart and reset.
module tb_vec_result_collector;

  localparam logic [63:0]  JUNK = 64'hA5A5_5A5A_F00D_BEEF;
  localparam logic [127:0] E1   = 128'h3332eeeed1231567d12315673332eeee;
  localparam logic [127:0] E2   = 128'h3232eeeed0231467d02314673232eeee;
  localparam logic [127:0] E3   = 128'h0123456789abcdef3332eeeed1241568;

  logic         clk = 1'b0;
  logic         reset, start, alu_done, vd_ready;
  logic [2:0]   vsew;
  logic [255:0] lane_data;
  logic [39:0]  lane_idx;
  logic [3:0]   lane_valid;
  logic [127:0] vd;
  logic         vd_valid, busy, err;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;

  vec_result_collector #(.VLEN(128), .LANE_WIDTH(3'd4), .NB_LANES(2'd2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vsew       (vsew),
    .lane_data  (lane_data),
    .lane_idx   (lane_idx),
    .lane_valid (lane_valid),
    .alu_done   (alu_done),
    .vd         (vd),
    .vd_valid   (vd_valid),
    .vd_ready   (vd_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start      = 1'b0;
    lane_valid = '0;
    alu_done   = 1'b0;
  endtask

  task automatic set_lane(input int n, input int idx, input logic [63:0] data);
    lane_idx[n*10 +: 10]  = idx[9:0];
    lane_data[n*64 +: 64] = data;
    lane_valid[n]         = 1'b1;
  endtask

  // Drives four consecutive chunks of v starting at chunk first, junk above the chunk.
  task automatic drive_pass(input int first, input int cw, input logic [127:0] v);
    logic [63:0] cm;
    logic [63:0] word;
    int          idx;
    cm = (64'd1 << cw) - 64'd1;
    for (int n = 0; n < 4; n++) begin
      idx  = (first + n) * cw;
      word = 64'(v >> idx);
      set_lane(n, idx, (JUNK & ~cm) | (word & cm));
    end
  endtask

  task automatic begin_collect(input logic [2:0] sew);
    start = 1'b1;
    vsew  = sew;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_done = 1'b0; vd_ready = 1'b0;
    vsew = 3'd0; lane_data = '0; lane_idx = '0; lane_valid = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_vd", vd, '0);
    check("rst_vd_valid", vd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // 16-bit chunks, two passes of four lanes.
    begin_collect(3'd1);
    check("t1_busy", busy, 1);
    drive_pass(0, 16, E1);
    tick();
    check("t1_mid_valid", vd_valid, 0);
    check("t1_mid_busy", busy, 1);
    drive_pass(4, 16, E1);
    alu_done = 1'b1;
    tick();
    check("t1_valid", vd_valid, 1);
    check("t1_vd", vd, E1);
    check("t1_err", err, 0);
    vd_ready = 1'b1;
    tick();
    vd_ready = 1'b0;
    check("t1_acc_valid", vd_valid, 0);
    check("t1_acc_busy", busy, 0);
    check("t1_acc_vd_kept", vd, E1);

    // 8-bit chunks, four passes: busy for four cycles, vd_valid on the fifth.
    begin_collect(3'd0);
    check("t2_vd_cleared", vd, '0);
    busy_cycles = 0;
    for (int p = 0; p < 4; p++) begin
      if (busy) busy_cycles++;
      drive_pass(p * 4, 8, E2);
      tick();
    end
    check("t2_busy_cycles", 128'(busy_cycles), 128'd4);
    check("t2_valid", vd_valid, 1);
    check("t2_vd", vd, E2);
    // Handoff and new start in the same cycle.
    vd_ready = 1'b1;
    start    = 1'b1;
    vsew     = 3'd1;
    tick();
    vd_ready = 1'b0;
    check("t2_restart_busy", busy, 1);
    check("t2_restart_valid", vd_valid, 0);
    check("t2_restart_vd", vd, '0);

    // vsew=3 capped to 16-bit chunks; back-pressure holds vd stable.
    begin_collect(3'd3);
    drive_pass(0, 16, E3);
    tick();
    drive_pass(4, 16, E3);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", vd_valid, 1);
      check("t3_hold_vd", vd, E3);
      tick();
    end
    vd_ready = 1'b1;
    tick();
    vd_ready = 1'b0;
    check("t3_rel_valid", vd_valid, 0);
    check("t3_rel_busy", busy, 0);

    // Same-cycle duplicate: later lane wins, no error.
    begin_collect(3'd1);
    set_lane(0, 0, 64'h1111);
    set_lane(1, 0, 64'h2222);
    tick();
    check("dup_same_vd", vd, 128'h2222);
    check("dup_same_err", err, 0);
    set_lane(0, 0, 64'h3333);
    tick();
    check("dup_later_vd", vd, 128'h3333);
    check("dup_later_err", err, 0);
    check("dup_not_done", vd_valid, 0);
    set_lane(1, 130, 64'hffff);
    tick();
    check("idx130_err", err, 1);
    check("idx130_vd", vd, 128'h3333);
    check("idx130_busy", busy, 1);

    begin_collect(3'd1);
    check("start_clears_err", err, 0);
    set_lane(3, 128, 64'hbeef);
    tick();
    check("idx128_err", err, 1);
    check("idx128_vd", vd, '0);

    begin_collect(3'd0);
    set_lane(2, 4, 64'h55);
    tick();
    check("misalign_err", err, 1);
    check("misalign_vd", vd, '0);

    // alu_done with only three of four passes delivered.
    begin_collect(3'd0);
    drive_pass(0, 8, E2);
    tick();
    drive_pass(4, 8, E2);
    tick();
    drive_pass(8, 8, E2);
    alu_done = 1'b1;
    tick();
    check("early_done_err", err, 1);
    check("early_done_busy", busy, 1);
    drive_pass(12, 8, E2);
    tick();
    check("late_pass_valid", vd_valid, 1);
    check("late_pass_vd", vd, E2);
    check("late_pass_err_sticky", err, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hold_rst_vd", vd, '0);
    check("hold_rst_valid", vd_valid, 0);
    check("hold_rst_err", err, 0);

    set_lane(0, 0, 64'h77);
    tick();
    check("idle_lane_err", err, 1);
    check("idle_lane_vd", vd, '0);
    check("idle_lane_busy", busy, 0);

    // Restart mid-collection; start beats same-cycle lane writes.
    begin_collect(3'd1);
    drive_pass(0, 16, E1);
    tick();
    drive_pass(4, 16, E1);
    start = 1'b1;
    vsew  = 3'd1;
    tick();
    check("restart_busy", busy, 1);
    check("restart_vd", vd, '0);
    check("restart_err", err, 0);
    drive_pass(4, 16, E1);
    tick();
    check("restart_partial", vd_valid, 0);
    drive_pass(0, 16, E1);
    tick();
    check("restart_valid", vd_valid, 1);
    check("restart_vd_final", vd, E1);

    set_lane(2, 32, 64'h9999);
    tick();
    check("hold_lane_err", err, 1);
    check("hold_lane_vd", vd, E1);
    check("hold_lane_valid", vd_valid, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_vd", vd, '0);
    check("rst2_valid", vd_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
